// File: rtl/conv_stream_driver.sv
// ============================================================================
// conv_stream_driver : loads filter/IF words, starts the accelerator, drains results
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module conv_stream_driver #(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_WIDTH = 17,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CNT_WIDTH-1:0]    cfg_filter_words,
  input  logic [CNT_WIDTH-1:0]    cfg_if_words,
  input  logic [CNT_WIDTH-1:0]    cfg_result_words,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic [DATA_WIDTH-1:0]   filter_buff_input,
  output logic                    filter_buff_write_en,
  output logic [DATA_WIDTH-1:0]   if_buff_input,
  output logic                    if_buff_write_en,
  output logic                    start,
  input  logic                    Done,
  output logic                    read_buffer_result,
  input  logic [RESULT_WIDTH-1:0] par_sum,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RESULT_WIDTH-1:0] out_data,
  output logic                    busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_F  = 3'd1,
    ST_LOAD_IF = 3'd2,
    ST_START   = 3'd3,
    ST_WAIT    = 3'd4,
    ST_DRAIN   = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] c_CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);

  state_t                  r_state, r_next;
  logic [CNT_WIDTH-1:0]    r_f_cnt, r_if_cnt, r_res_cnt;
  logic                    r_rst_done;
  logic                    r_pending;
  logic                    r_out_valid;
  logic [RESULT_WIDTH-1:0] r_out_data;
  logic [DATA_WIDTH-1:0]   r_fbuf, r_ifbuf;
  logic                    r_fwe, r_ifwe;

  logic w_accept, w_xfer, w_xfer_f, w_xfer_if, w_hs, w_strobe;

  assign cfg_ready = (r_state == ST_IDLE) && r_rst_done;
  assign in_ready  = (r_state == ST_LOAD_F) || (r_state == ST_LOAD_IF);
  assign w_accept  = cfg_valid && cfg_ready;
  assign w_xfer    = in_valid && in_ready;
  assign w_xfer_f  = w_xfer && (r_state == ST_LOAD_F);
  assign w_xfer_if = w_xfer && (r_state == ST_LOAD_IF);
  assign w_hs      = r_out_valid && out_ready;
  // One read in flight: issue when the output slot is empty and idle, or frees this cycle
  assign w_strobe  = (r_state == ST_DRAIN) && (r_res_cnt != c_CNT_ZERO) &&
                     ((!r_out_valid && !r_pending) || w_hs);

  assign start                = (r_state == ST_START);
  assign busy                 = (r_state != ST_IDLE);
  assign read_buffer_result   = w_strobe;
  assign out_valid            = r_out_valid;
  assign out_data             = r_out_data;
  assign filter_buff_input    = r_fbuf;
  assign filter_buff_write_en = r_fwe;
  assign if_buff_input        = r_ifbuf;
  assign if_buff_write_en     = r_ifwe;

  always_comb begin
    r_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (cfg_filter_words != c_CNT_ZERO)  r_next = ST_LOAD_F;
          else if (cfg_if_words != c_CNT_ZERO) r_next = ST_LOAD_IF;
          else                                 r_next = ST_START;
        end
      end
      ST_LOAD_F: begin
        if (w_xfer && (r_f_cnt == c_CNT_ONE))
          r_next = (r_if_cnt == c_CNT_ZERO) ? ST_START : ST_LOAD_IF;
      end
      ST_LOAD_IF: begin
        if (w_xfer && (r_if_cnt == c_CNT_ONE)) r_next = ST_START;
      end
      ST_START: r_next = ST_WAIT;
      ST_WAIT: begin
        if (Done) r_next = (r_res_cnt == c_CNT_ZERO) ? ST_IDLE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_hs && (r_res_cnt == c_CNT_ZERO) && !r_pending) r_next = ST_IDLE;
      end
      default: r_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_rst_done  <= 1'b0;
      r_f_cnt     <= '0;
      r_if_cnt    <= '0;
      r_res_cnt   <= '0;
      r_pending   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_fbuf      <= '0;
      r_ifbuf     <= '0;
      r_fwe       <= 1'b0;
      r_ifwe      <= 1'b0;
    end else begin
      r_state    <= r_next;
      r_rst_done <= 1'b1;

      if (w_accept) begin
        r_f_cnt   <= cfg_filter_words;
        r_if_cnt  <= cfg_if_words;
        r_res_cnt <= cfg_result_words;
      end else begin
        if (w_xfer_f && (r_f_cnt != c_CNT_ZERO))   r_f_cnt   <= r_f_cnt - c_CNT_ONE;
        if (w_xfer_if && (r_if_cnt != c_CNT_ZERO)) r_if_cnt  <= r_if_cnt - c_CNT_ONE;
        if (w_strobe)                              r_res_cnt <= r_res_cnt - c_CNT_ONE;
      end

      r_fwe  <= w_xfer_f;
      r_ifwe <= w_xfer_if;
      if (w_xfer_f)  r_fbuf  <= in_data;
      if (w_xfer_if) r_ifbuf <= in_data;

      // par_sum is valid the cycle after the strobe, which is when r_pending is set
      r_pending <= w_strobe;
      if (r_pending) begin
        r_out_valid <= 1'b1;
        r_out_data  <= par_sum;
      end else if (w_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_stream_driver.sv
// ============================================================================
// tb_conv_stream_driver : table-driven jobs plus stall and mid-drain reset sequences
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_conv_stream_driver;

  localparam int DW = 8;
  localparam int RW = 17;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_valid, cfg_ready;
  logic [CW-1:0] cfg_filter_words, cfg_if_words, cfg_result_words;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic [DW-1:0] filter_buff_input, if_buff_input;
  logic          filter_buff_write_en, if_buff_write_en;
  logic          start, Done, read_buffer_result;
  logic [RW-1:0] par_sum;
  logic          out_valid, out_ready;
  logic [RW-1:0] out_data;
  logic          busy;

  always #5 clk = ~clk;

  conv_stream_driver #(.DATA_WIDTH(DW), .RESULT_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_filter_words(cfg_filter_words), .cfg_if_words(cfg_if_words),
    .cfg_result_words(cfg_result_words),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .filter_buff_input(filter_buff_input), .filter_buff_write_en(filter_buff_write_en),
    .if_buff_input(if_buff_input), .if_buff_write_en(if_buff_write_en),
    .start(start), .Done(Done),
    .read_buffer_result(read_buffer_result), .par_sum(par_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Observed-event counters and scoreboards
  int            n_fw, n_iw, n_start, n_strb, n_hs, n_xfer, n_early, seq;
  logic [DW-1:0] exp_f[$], exp_i[$], words[$];
  logic [RW-1:0] exp_r[$];
  logic          hold_prev = 1'b0;
  logic [RW-1:0] hold_data;
  logic          ps_load = 1'b0;
  logic [RW-1:0] ps_next;

  // Result buffer model: data appears one cycle after the strobe, garbage otherwise
  always @(posedge clk) begin
    #1;
    if (ps_load) begin
      par_sum = ps_next;
      ps_load = 1'b0;
    end else begin
      par_sum = RW'(17'h00BAD);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      hold_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) n_xfer++;
      if (filter_buff_write_en) begin
        if (exp_f.size() == 0) check("fw_extra", 1, 0);
        else                   check("fw_data", filter_buff_input, exp_f.pop_front());
        n_fw++;
      end
      if (if_buff_write_en) begin
        if (exp_i.size() == 0) check("iw_extra", 1, 0);
        else                   check("iw_data", if_buff_input, exp_i.pop_front());
        n_iw++;
      end
      if (start) n_start++;
      if (read_buffer_result) begin
        if (n_start == 0) n_early++;
        n_strb++;
        seq++;
        ps_next = RW'(32'h0001_0000 + seq * 4099);
        exp_r.push_back(ps_next);
        ps_load = 1'b1;
      end
      if (hold_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_data);
      end
      if (out_valid && out_ready) begin
        n_hs++;
        if (exp_r.size() == 0) check("res_extra", 1, 0);
        else                   check("res_data", out_data, exp_r.pop_front());
      end
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
    end
  end

  typedef struct {
    int f, i, r;
    bit gap, early, stall;
    int e_fw, e_iw, e_st, e_strb;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr(input int f, input int i, input int base);
    n_fw = 0; n_iw = 0; n_start = 0; n_strb = 0; n_hs = 0; n_xfer = 0; n_early = 0;
    exp_f.delete(); exp_i.delete(); exp_r.delete(); words.delete();
    for (int k = 0; k < f + i; k++) begin
      words.push_back(DW'(base + 7 * k));
      if (k < f) exp_f.push_back(DW'(base + 7 * k));
      else       exp_i.push_back(DW'(base + 7 * k));
    end
  endtask

  task automatic cfg(input int f, input int i, input int r);
    int b = 0;
    while (!cfg_ready && b < 20) begin tick(); b++; end
    check("cfg_ready_before_job", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_filter_words = CW'(f); cfg_if_words = CW'(i); cfg_result_words = CW'(r);
    tick();
    cfg_valid = 1'b0;
    check("busy_after_accept", busy, 1);
  endtask

  task automatic stream(input bit gap);
    int k = 0;
    int cyc = 0;
    while (k < words.size() && cyc < 200) begin
      in_valid = gap ? ((cyc % 3) != 1) : 1'b1;
      in_data  = words[k];
      @(negedge clk);
      if (in_valid && in_ready) k++;
      tick();
      cyc++;
    end
    check("stream_complete", k, words.size());
    // Keep offering junk so any over-consumption shows up in n_xfer
    in_valid = 1'b1; in_data = 8'hEE;
    repeat (3) tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_start();
    int cyc = 0;
    while (n_start == 0 && cyc < 50) begin tick(); cyc++; end
    check("start_seen", n_start, 1);
  endtask

  task automatic run_job(input vec_t v, input int base);
    int cyc = 0;
    clr(v.f, v.i, base);
    out_ready = v.stall ? 1'b0 : 1'b1;
    if (v.early) Done = 1'b1;
    cfg(v.f, v.i, v.r);
    stream(v.gap);
    wait_start();
    repeat (2) tick();
    Done = 1'b1;
    while (busy && cyc < 300) begin
      if (v.stall) out_ready = (cyc % 2) == 1;
      tick();
      cyc++;
    end
    Done = 1'b0; out_ready = 1'b1;
    tick();
    check("job_idle", busy, 0);
    check("job_fwrites", n_fw, v.e_fw);
    check("job_iwrites", n_iw, v.e_iw);
    check("job_starts", n_start, v.e_st);
    check("job_strobes", n_strb, v.e_strb);
    check("job_handshakes", n_hs, v.e_strb);
    check("job_transfers", n_xfer, v.e_fw + v.e_iw);
    check("job_early_strobes", n_early, 0);
    check("job_results_left", exp_r.size(), 0);
  endtask

  function automatic logic [63:0] all_outs();
    return {23'd0, cfg_ready, in_ready, filter_buff_input, filter_buff_write_en,
            if_buff_input, if_buff_write_en, start, read_buffer_result,
            out_valid, out_data, busy};
  endfunction

  initial begin
    //          f  i  r  gap early stall  fw iw st strb
    tbl[0] = '{2, 3, 2, 0, 0, 0,  2, 3, 1, 2};
    tbl[1] = '{0, 4, 1, 0, 0, 0,  0, 4, 1, 1};
    tbl[2] = '{0, 0, 0, 0, 0, 0,  0, 0, 1, 0};
    tbl[3] = '{1, 2, 3, 1, 0, 1,  1, 2, 1, 3};
    tbl[4] = '{2, 2, 1, 1, 1, 0,  2, 2, 1, 1};
    tbl[5] = '{3, 0, 2, 0, 0, 1,  3, 0, 1, 2};

    rst = 1'b0; cfg_valid = 1'b0; cfg_filter_words = '0; cfg_if_words = '0;
    cfg_result_words = '0; in_valid = 1'b0; in_data = '0; Done = 1'b0; out_ready = 1'b1;
    seq = 0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("cfg_ready_before_first_edge", cfg_ready, 0);
    tick();
    check("cfg_ready_after_release", cfg_ready, 1);
    check("busy_after_release", busy, 0);

    for (int t = 0; t < 6; t++) run_job(tbl[t], 16 + 32 * t);

    // out_ready held low for 5 cycles with the first result valid
    begin
      int cyc = 0;
      clr(1, 1, 8'h55);
      out_ready = 1'b0;
      cfg(1, 1, 2);
      stream(1'b0);
      wait_start();
      Done = 1'b1;
      while (!out_valid && cyc < 30) begin tick(); cyc++; end
      Done = 1'b0;
      check("stall_first_valid", out_valid, 1);
      repeat (5) tick();
      check("stall_single_strobe", n_strb, 1);
      check("stall_still_valid", out_valid, 1);
      out_ready = 1'b1;
      cyc = 0;
      while (busy && cyc < 30) begin tick(); cyc++; end
      check("stall_idle", busy, 0);
      check("stall_strobes", n_strb, 2);
      check("stall_handshakes", n_hs, 2);
    end

    // Reset while a drain read is pending
    begin
      int cyc = 0;
      clr(0, 0, 0);
      out_ready = 1'b1;
      cfg(0, 0, 3);
      wait_start();
      Done = 1'b1;
      @(negedge clk);
      while (!read_buffer_result && cyc < 30) begin @(negedge clk); cyc++; end
      check("drain_strobe_seen", read_buffer_result, 1);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("midjob_reset_outputs", all_outs(), 64'd0);
      Done = 1'b0;
      @(negedge clk);
      check("cfg_ready_in_reset", cfg_ready, 0);
      rst = 1'b1;
      exp_r.delete();
      tick();
      check("cfg_ready_after_midjob_reset", cfg_ready, 1);
      for (int k = 0; k < 4; k++) begin
        check("no_capture_after_reset", out_valid, 0);
        check("idle_after_reset", busy, 0);
        tick();
      end
    end

    run_job(tbl[0], 8'hC0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
